// File: rtl/hilo_pkg.sv
// Shared encodings and defaults for the HI/LO sequencer: op_sel codes, FSM states,
// default latencies and the latency-counter width helper.
package hilo_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10
    } state_e;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DIV_CYCLES  = 33;
    localparam int DEF_MULT_CYCLES = 33;

    // Wide enough to hold the larger latency without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter timing the divider/multiplier latency; is_one_o flags the
// final cycle so the owner can capture on that edge.
module hilo_lat_counter
    import hilo_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register bank and sequencer for the multicycle divider/multiplier.
// Define HILO_FWD_EN to bypass pending writes combinationally onto hi/lo.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             div_exc,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    output logic             div_init,
    output logic             mult_init,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(DIV_CYCLES, MULT_CYCLES);

    state_e           state_q, state_d;
    logic             op_div_q, op_div_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_is_one;

    hilo_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_load_val),
        .is_one_o   (cnt_is_one)
    );

    assign cnt_load_val = op_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_comb begin
        state_d    = state_q;
        op_div_d   = op_div_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        div_init   = 1'b0;
        mult_init  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    div_zero_d = 1'b0;
                    case (op_sel)
                        OP_DIV: begin
                            op_div_d = 1'b1;
                            state_d  = S_LAUNCH;
                        end
                        OP_MULT: begin
                            op_div_d = 1'b0;
                            state_d  = S_LAUNCH;
                        end
                        OP_MTHI: hi_d = wr_data;
                        OP_MTLO: lo_d = wr_data;
                        default: ;
                    endcase
                end
            end
            S_LAUNCH: begin
                busy      = 1'b1;
                div_init  = op_div_q;
                mult_init = ~op_div_q;
                cnt_load  = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                busy   = 1'b1;
                cnt_en = 1'b1;
                // Last latency cycle: the unit's result is stable, capture it.
                if (cnt_is_one) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (op_div_q) begin
                        if (div_exc) begin
                            div_zero_d = 1'b1;
                        end else begin
                            hi_d = div_hi;
                            lo_d = div_lo;
                        end
                    end else begin
                        hi_d = mult_hi;
                        lo_d = mult_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_div_q   <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign done     = done_q;
    assign div_zero = div_zero_q;

    // Next-state values already encode exactly what the bypass must show.
`ifdef HILO_FWD_EN
    assign hi = hi_d;
    assign lo = lo_d;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with behavioural divider/multiplier models.
// Honours HILO_FWD_EN for the same-cycle MTHI/MTLO expectations.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int WIDTH       = 32;
    localparam int DIV_CYCLES  = 33;
    localparam int MULT_CYCLES = 33;

    logic             clk;
    logic             reset;
    logic             op_start;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] div_hi, div_lo, mult_hi, mult_lo;
    logic             div_exc;
    logic             div_init, mult_init, busy, done, div_zero;
    logic [WIDTH-1:0] hi, lo;

    logic [WIDTH-1:0] dividend, divisor, mcand, mplier;
    int               divCnt, multCnt;

    int vectors, miscompares;
    int busyCnt, divInitCnt, multInitCnt, doneCnt, doneAt, divInitAt, multInitAt;

    hilo_ctrl #(
        .WIDTH       (WIDTH),
        .DIV_CYCLES  (DIV_CYCLES),
        .MULT_CYCLES (MULT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .op_sel    (op_sel),
        .wr_data   (wr_data),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .div_exc   (div_exc),
        .mult_hi   (mult_hi),
        .mult_lo   (mult_lo),
        .div_init  (div_init),
        .mult_init (mult_init),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: result becomes stable one cycle before the latency expires.
    always @(posedge clk) begin
        if (reset) begin
            divCnt  <= 0;
            div_hi  <= '0;
            div_lo  <= '0;
            div_exc <= 1'b0;
        end else if (div_init) begin
            divCnt  <= DIV_CYCLES - 1;
            div_hi  <= '0;
            div_lo  <= '0;
            div_exc <= 1'b0;
        end else if (divCnt != 0) begin
            divCnt <= divCnt - 1;
            if (divCnt == 1) begin
                if (divisor == '0) begin
                    div_exc <= 1'b1;
                    div_hi  <= dividend;
                    div_lo  <= '1;
                end else begin
                    div_hi <= dividend % divisor;
                    div_lo <= dividend / divisor;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            multCnt <= 0;
            mult_hi <= '0;
            mult_lo <= '0;
        end else if (mult_init) begin
            multCnt <= MULT_CYCLES - 1;
            mult_hi <= '0;
            mult_lo <= '0;
        end else if (multCnt != 0) begin
            multCnt <= multCnt - 1;
            if (multCnt == 1) begin
                {mult_hi, mult_lo} <= 64'(mcand) * 64'(mplier);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] sel, input logic [WIDTH-1:0] data);
        op_start = start;
        op_sel   = sel;
        wr_data  = data;
    endtask

    // Watches n cycles; after the first sample op_sel becomes selAfter and op_start optionally drops.
    task automatic observe(input int n, input bit dropStart, input logic [1:0] selAfter);
        busyCnt = 0; divInitCnt = 0; multInitCnt = 0; doneCnt = 0;
        doneAt = 0; divInitAt = 0; multInitAt = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (div_init) begin divInitCnt++; if (divInitAt == 0) divInitAt = i; end
            if (mult_init) begin multInitCnt++; if (multInitAt == 0) multInitAt = i; end
            if (done) begin doneCnt++; if (doneAt == 0) doneAt = i; end
            if (i == 1) begin
                op_sel = selAfter;
                if (dropStart) op_start = 1'b0;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        dividend = '0; divisor = '0; mcand = '0; mplier = '0;
        reset = 1'b1;
        applyStimulus(1'b0, OP_DIV, '0);

        // 1: reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_div_init", 32'(div_init), 32'h0);
        checkOutput("rst_mult_init", 32'(mult_init), 32'h0);
        checkOutput("rst_div_zero", 32'(div_zero), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 2: DIV 100 / 7 -> remainder 2, quotient 14
        dividend = 32'd100; divisor = 32'd7;
        applyStimulus(1'b1, OP_DIV, '0);
        observe(40, 1'b1, OP_DIV);
        checkOutput("div_init_count", 32'(divInitCnt), 32'd1);
        checkOutput("div_init_at", 32'(divInitAt), 32'd1);
        checkOutput("div_mult_init_count", 32'(multInitCnt), 32'd0);
        checkOutput("div_busy_cycles", 32'(busyCnt), 32'd34);
        checkOutput("div_done_count", 32'(doneCnt), 32'd1);
        checkOutput("div_done_at", 32'(doneAt), 32'd35);
        checkOutput("div_hi", hi, 32'd2);
        checkOutput("div_lo", lo, 32'd14);
        checkOutput("div_zero_clear", 32'(div_zero), 32'd0);

        // 3: preload, then divide by zero leaves hi/lo untouched
        applyStimulus(1'b1, OP_MTHI, 32'h11);
        @(negedge clk);
        applyStimulus(1'b1, OP_MTLO, 32'h22);
        @(negedge clk);
        dividend = 32'd55; divisor = 32'd0;
        applyStimulus(1'b1, OP_DIV, '0);
        observe(40, 1'b1, OP_DIV);
        checkOutput("dz_done_count", 32'(doneCnt), 32'd1);
        checkOutput("dz_done_at", 32'(doneAt), 32'd35);
        checkOutput("dz_div_zero", 32'(div_zero), 32'd1);
        checkOutput("dz_hi", hi, 32'h11);
        checkOutput("dz_lo", lo, 32'h22);
        @(negedge clk);
        checkOutput("dz_sticky", 32'(div_zero), 32'd1);

        // 4: MTHI / MTLO, which also clear the sticky div_zero
        applyStimulus(1'b1, OP_MTHI, 32'hDEADBEEF);
        #1;
`ifdef HILO_FWD_EN
        checkOutput("mthi_same_cycle", hi, 32'hDEADBEEF);
`else
        checkOutput("mthi_same_cycle", hi, 32'h11);
`endif
        checkOutput("mthi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'hDEADBEEF);
        checkOutput("mthi_div_zero", 32'(div_zero), 32'd0);
        applyStimulus(1'b1, OP_MTLO, 32'h12345678);
        #1;
`ifdef HILO_FWD_EN
        checkOutput("mtlo_same_cycle", lo, 32'h12345678);
`else
        checkOutput("mtlo_same_cycle", lo, 32'h22);
`endif
        @(negedge clk);
        applyStimulus(1'b0, OP_DIV, '0);
        checkOutput("mtlo_lo", lo, 32'h12345678);
        checkOutput("mtlo_hi_kept", hi, 32'hDEADBEEF);
        checkOutput("mtlo_busy", 32'(busy), 32'd0);
        checkOutput("mtlo_done", 32'(done), 32'd0);
        @(negedge clk);

        // 5: MULT 0x9ABCDEF0 * 0x10, DIV request held throughout
        mcand = 32'h9ABCDEF0; mplier = 32'h10;
        dividend = 32'd1000; divisor = 32'd33;
        applyStimulus(1'b1, OP_MULT, '0);
        observe(35, 1'b0, OP_DIV);
        checkOutput("mul_init_count", 32'(multInitCnt), 32'd1);
        checkOutput("mul_init_at", 32'(multInitAt), 32'd1);
        checkOutput("mul_no_div_init", 32'(divInitCnt), 32'd0);
        checkOutput("mul_busy_cycles", 32'(busyCnt), 32'd34);
        checkOutput("mul_done_at", 32'(doneAt), 32'd35);
        checkOutput("mul_hi", hi, 32'h9);
        checkOutput("mul_lo", lo, 32'hABCDEF00);
        checkOutput("mul_busy_after", 32'(busy), 32'd0);
        observe(40, 1'b1, OP_DIV);
        checkOutput("hold_div_init_at", 32'(divInitAt), 32'd1);
        checkOutput("hold_div_init_count", 32'(divInitCnt), 32'd1);
        checkOutput("hold_mult_init_count", 32'(multInitCnt), 32'd0);
        checkOutput("hold_done_at", 32'(doneAt), 32'd35);
        checkOutput("hold_hi", hi, 32'd10);
        checkOutput("hold_lo", lo, 32'd30);

        // 6: reset in WAIT with cnt at 20 aborts the op
        dividend = 32'd77; divisor = 32'd5;
        applyStimulus(1'b1, OP_DIV, '0);
        observe(15, 1'b1, OP_DIV);
        checkOutput("abort_busy_before", 32'(busyCnt), 32'd15);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);
        checkOutput("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        observe(40, 1'b1, OP_DIV);
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        checkOutput("abort_no_busy", 32'(busyCnt), 32'd0);
        checkOutput("abort_no_init", 32'(divInitCnt + multInitCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
